// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard / forwarding controller.
// The in-flight tag is stored with a fixed-width rd field (TAG_RD_W) so the
// struct can be shared by modules with different REG_AW values. REG_AW must
// not exceed TAG_RD_W.
package hazard_pkg;

    localparam int TAG_RD_W = 8;

    // Forward select value meaning "take the operand from the register file".
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                valid;
        logic [TAG_RD_W-1:0] rd;
        logic                regwrite;
        logic                memread;
    } hazard_tag_t;

    // Empty pipeline slot.
    localparam hazard_tag_t BUBBLE_TAG = '0;

endpackage

// File: rtl/hazard_tag_pipe.sv
// Shift register of in-flight destination tags. Slot 0 mirrors EX, slot 1
// MEM, and so on. The whole pipe holds while 'hold' is high; otherwise every
// tag moves one slot older and slot 0 takes in_tag (the caller supplies
// BUBBLE_TAG when nothing real enters EX).
module hazard_tag_pipe
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  hazard_tag_t in_tag,
    output hazard_tag_t slots [DEPTH]
);

    hazard_tag_t slot_reg [DEPTH];

    // Advance all slots together unless the pipe is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                slot_reg[j] <= BUBBLE_TAG;
            end
        end else if (!hold) begin
            slot_reg[0] <= in_tag;
            for (int j = 1; j < DEPTH; j++) begin
                slot_reg[j] <= slot_reg[j-1];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_out
            assign slots[gi] = slot_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the in-order pipeline.
// Tracks in-flight destination tags, resolves EX operand forward selects one
// stage early (in ID) and registers them for the EX cycle, and produces the
// load-use stall, memory-freeze and taken-branch squash controls.
// Optional: define HAZARD_PERF_EN to add saturating 32-bit event counters
// perf_loaduse, perf_flush and perf_fwd.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int FWD_DEPTH    = 2,
    parameter int LOAD_FWD_SEL = 2,
    parameter int SELW         = $clog2(FWD_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              mem_stall,
    input  logic              ex_branch_taken,
    output logic [SELW-1:0]   fwd_sel_rs1,
    output logic [SELW-1:0]   fwd_sel_rs2,
    output logic              stall_if_id,
    output logic              bubble_ex,
    output logic              flush_if_id
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_loaduse,
    output logic [31:0]       perf_flush,
    output logic [31:0]       perf_fwd
`endif
);

    localparam int NSLOT = FWD_DEPTH + 1;

    hazard_tag_t       slots [NSLOT];
    hazard_tag_t       id_tag;
    hazard_tag_t       ins_tag;
    logic              match_rs1 [NSLOT];
    logic              match_rs2 [NSLOT];
    logic [SELW-1:0]   fwd_sel_rs1_next;
    logic [SELW-1:0]   fwd_sel_rs2_next;
    logic [SELW-1:0]   fwd_sel_rs1_reg;
    logic [SELW-1:0]   fwd_sel_rs2_reg;
    logic              lu_rs1;
    logic              lu_rs2;
    logic              load_use;

    // Tag describing the instruction currently in ID.
    always_comb begin
        id_tag          = BUBBLE_TAG;
        id_tag.valid    = 1'b1;
        id_tag.rd       = TAG_RD_W'(id_rd);
        id_tag.regwrite = id_regwrite;
        id_tag.memread  = id_memread;
    end

    // A slot matches an operand only if it really writes a nonzero rd that
    // the ID instruction actually reads.
    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_match
            assign match_rs1[gi] = slots[gi].valid && slots[gi].regwrite &&
                                   (slots[gi].rd != '0) &&
                                   (slots[gi].rd == TAG_RD_W'(id_rs1)) && id_rs1_used;
            assign match_rs2[gi] = slots[gi].valid && slots[gi].regwrite &&
                                   (slots[gi].rd != '0) &&
                                   (slots[gi].rd == TAG_RD_W'(id_rs2)) && id_rs2_used;
        end
    endgenerate

    // Youngest-match priority: scan oldest to youngest so the youngest hit
    // overrides. The WB slot is never a forward source (write-through RF).
    // A hit on a load whose data is not yet at a usable tap is a load-use.
    always_comb begin
        fwd_sel_rs1_next = SELW'(FWD_RF);
        fwd_sel_rs2_next = SELW'(FWD_RF);
        lu_rs1           = 1'b0;
        lu_rs2           = 1'b0;
        for (int j = FWD_DEPTH - 1; j >= 0; j--) begin
            if (match_rs1[j]) begin
                fwd_sel_rs1_next = SELW'(j + 1);
                lu_rs1           = slots[j].memread && ((j + 1) < LOAD_FWD_SEL);
            end
            if (match_rs2[j]) begin
                fwd_sel_rs2_next = SELW'(j + 1);
                lu_rs2           = slots[j].memread && ((j + 1) < LOAD_FWD_SEL);
            end
        end
    end

    // A bubble in ID cannot depend on anything, so it never stalls.
    assign load_use = id_valid && (lu_rs1 || lu_rs2);

    // Priority: mem_stall > taken branch > load-use.
    assign stall_if_id = mem_stall || (!ex_branch_taken && load_use);
    assign bubble_ex   = !mem_stall && (ex_branch_taken || load_use);
    assign flush_if_id = !mem_stall && ex_branch_taken;

    // Only a real, non-stalled, non-squashed ID instruction enters EX.
    assign ins_tag = (id_valid && !load_use && !ex_branch_taken) ? id_tag : BUBBLE_TAG;

    hazard_tag_pipe #(
        .DEPTH (NSLOT)
    ) u_tag_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (mem_stall),
        .in_tag (ins_tag),
        .slots  (slots)
    );

    // Register the selects as the consumer moves into EX; a bubble gets 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_sel_rs1_reg <= SELW'(FWD_RF);
            fwd_sel_rs2_reg <= SELW'(FWD_RF);
        end else if (!mem_stall) begin
            if (ex_branch_taken || load_use) begin
                fwd_sel_rs1_reg <= SELW'(FWD_RF);
                fwd_sel_rs2_reg <= SELW'(FWD_RF);
            end else begin
                fwd_sel_rs1_reg <= fwd_sel_rs1_next;
                fwd_sel_rs2_reg <= fwd_sel_rs2_next;
            end
        end
    end

    assign fwd_sel_rs1 = fwd_sel_rs1_reg;
    assign fwd_sel_rs2 = fwd_sel_rs2_reg;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_loaduse_reg;
    logic [31:0] perf_flush_reg;
    logic [31:0] perf_fwd_reg;

    // Saturating event counters, frozen while the memory system stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_loaduse_reg <= '0;
            perf_flush_reg   <= '0;
            perf_fwd_reg     <= '0;
        end else if (!mem_stall) begin
            if (load_use && !ex_branch_taken && (perf_loaduse_reg != '1)) begin
                perf_loaduse_reg <= perf_loaduse_reg + 32'd1;
            end
            if (ex_branch_taken && (perf_flush_reg != '1)) begin
                perf_flush_reg <= perf_flush_reg + 32'd1;
            end
            if (((fwd_sel_rs1_reg != '0) || (fwd_sel_rs2_reg != '0)) &&
                (perf_fwd_reg != '1)) begin
                perf_fwd_reg <= perf_fwd_reg + 32'd1;
            end
        end
    end

    assign perf_loaduse = perf_loaduse_reg;
    assign perf_flush   = perf_flush_reg;
    assign perf_fwd     = perf_fwd_reg;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed vector table, a randomized run against
// an in-flight instruction list model, and an off-edge asynchronous reset.
module tb_hazard_fwd_ctrl;

    localparam int REG_AW       = 5;
    localparam int FWD_DEPTH    = 2;
    localparam int LOAD_FWD_SEL = 2;
    localparam int SELW         = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              id_valid = 1'b0;
    logic [REG_AW-1:0] id_rs1 = '0;
    logic [REG_AW-1:0] id_rs2 = '0;
    logic              id_rs1_used = 1'b0;
    logic              id_rs2_used = 1'b0;
    logic [REG_AW-1:0] id_rd = '0;
    logic              id_regwrite = 1'b0;
    logic              id_memread = 1'b0;
    logic              mem_stall = 1'b0;
    logic              ex_branch_taken = 1'b0;
    logic [SELW-1:0]   fwd_sel_rs1;
    logic [SELW-1:0]   fwd_sel_rs2;
    logic              stall_if_id;
    logic              bubble_ex;
    logic              flush_if_id;
`ifdef HAZARD_PERF_EN
    logic [31:0]       perf_loaduse;
    logic [31:0]       perf_flush;
    logic [31:0]       perf_fwd;
`endif

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(
        .REG_AW       (REG_AW),
        .FWD_DEPTH    (FWD_DEPTH),
        .LOAD_FWD_SEL (LOAD_FWD_SEL)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .id_rd           (id_rd),
        .id_regwrite     (id_regwrite),
        .id_memread      (id_memread),
        .mem_stall       (mem_stall),
        .ex_branch_taken (ex_branch_taken),
        .fwd_sel_rs1     (fwd_sel_rs1),
        .fwd_sel_rs2     (fwd_sel_rs2),
        .stall_if_id     (stall_if_id),
        .bubble_ex       (bubble_ex),
        .flush_if_id     (flush_if_id)
`ifdef HAZARD_PERF_EN
        ,
        .perf_loaduse    (perf_loaduse),
        .perf_flush      (perf_flush),
        .perf_fwd        (perf_fwd)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // inflight[d] is the instruction that left ID d+1 cycles ago (counting
    // only cycles the pipe moved); its result is reachable at tap d+1.
    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
    } instr_t;

    instr_t inflight [FWD_DEPTH+1];
    int     m_sel1, m_sel2;
    int     cnt_lu, cnt_fl, cnt_fwd;

    task automatic model_reset();
        for (int d = 0; d <= FWD_DEPTH; d++) inflight[d] = '{0, 0, 0, 0};
        m_sel1 = 0; m_sel2 = 0;
        cnt_lu = 0; cnt_fl = 0; cnt_fwd = 0;
    endtask

    // Distance of the most recent in-flight writer of rs, or -1.
    function automatic int producer(int rs, bit used);
        if (!used || rs == 0) return -1;
        for (int d = 0; d <= FWD_DEPTH; d++)
            if (inflight[d].v && inflight[d].wr && inflight[d].rd == rs) return d;
        return -1;
    endfunction

    function automatic int tap_of(int d);
        if (d < 0) return 0;
        return (d + 1 <= FWD_DEPTH) ? d + 1 : 0;
    endfunction

    function automatic bit not_ready(int d);
        if (d < 0 || d + 1 > FWD_DEPTH) return 0;
        return inflight[d].ld && (d + 1 < LOAD_FWD_SEL);
    endfunction

    // ---------------- stimulus record ----------------
    typedef struct {
        bit v;
        int rs1; bit u1;
        int rs2; bit u2;
        int rd;  bit wr; bit ld;
        bit ms;  bit br;
        bit e_st; bit e_bu; bit e_fl;
        int e_s1; int e_s2;
    } vec_t;

    function automatic vec_t mk(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit wr, bit ld,
                                bit ms, bit br, bit est, bit ebu, bit efl, int es1, int es2);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
        t.rd = rd; t.wr = wr; t.ld = ld; t.ms = ms; t.br = br;
        t.e_st = est; t.e_bu = ebu; t.e_fl = efl; t.e_s1 = es1; t.e_s2 = es2;
        return t;
    endfunction

    // One cycle: drive at negedge, check combinational outputs, clock, check
    // registered selects. Returns what the DUT showed.
    task automatic step(input vec_t t, output bit a_st, output bit a_bu, output bit a_fl,
                        output int a_s1, output int a_s2);
        int d1, d2, n1, n2;
        bit haz, x_st, x_bu, x_fl;
        id_valid = t.v; id_rs1 = REG_AW'(t.rs1); id_rs2 = REG_AW'(t.rs2);
        id_rs1_used = t.u1; id_rs2_used = t.u2; id_rd = REG_AW'(t.rd);
        id_regwrite = t.wr; id_memread = t.ld;
        mem_stall = t.ms; ex_branch_taken = t.br;
        #1;
        d1 = producer(t.rs1, t.u1);
        d2 = producer(t.rs2, t.u2);
        n1 = tap_of(d1); n2 = tap_of(d2);
        haz  = t.v && (not_ready(d1) || not_ready(d2));
        x_st = t.ms || (!t.br && haz);
        x_bu = !t.ms && (t.br || haz);
        x_fl = !t.ms && t.br;
        chk("model_stall", int'(stall_if_id), int'(x_st));
        chk("model_bubble", int'(bubble_ex), int'(x_bu));
        chk("model_flush", int'(flush_if_id), int'(x_fl));
        a_st = stall_if_id; a_bu = bubble_ex; a_fl = flush_if_id;
        if (!t.ms) begin
            if (haz && !t.br) cnt_lu++;
            if (t.br) cnt_fl++;
            if (m_sel1 != 0 || m_sel2 != 0) cnt_fwd++;
        end
        @(posedge clk);
        if (!t.ms) begin
            for (int d = FWD_DEPTH; d > 0; d--) inflight[d] = inflight[d-1];
            if (t.v && !haz && !t.br) inflight[0] = '{1, t.rd, t.wr, t.ld};
            else                      inflight[0] = '{0, 0, 0, 0};
            if (t.br || haz) begin
                m_sel1 = 0; m_sel2 = 0;
            end else begin
                m_sel1 = n1; m_sel2 = n2;
            end
        end
        #1;
        chk("model_sel1", int'(fwd_sel_rs1), m_sel1);
        chk("model_sel2", int'(fwd_sel_rs2), m_sel2);
        a_s1 = fwd_sel_rs1; a_s2 = fwd_sel_rs2;
        @(negedge clk);
    endtask

    task automatic run_vec(input string tag, input vec_t t);
        bit st, bu, fl;
        int s1, s2;
        step(t, st, bu, fl, s1, s2);
        chk({tag, "_stall"}, int'(st), int'(t.e_st));
        chk({tag, "_bubble"}, int'(bu), int'(t.e_bu));
        chk({tag, "_flush"}, int'(fl), int'(t.e_fl));
        chk({tag, "_sel1"}, s1, t.e_s1);
        chk({tag, "_sel2"}, s2, t.e_s2);
        $display("%s: stall=%0d bubble=%0d flush=%0d sel1=%0d sel2=%0d", tag, st, bu, fl, s1, s2);
    endtask

    task automatic chk_perf(input string tag);
`ifdef HAZARD_PERF_EN
        chk({tag, "_perf_loaduse"}, int'(perf_loaduse), cnt_lu);
        chk({tag, "_perf_flush"}, int'(perf_flush), cnt_fl);
        chk({tag, "_perf_fwd"}, int'(perf_fwd), cnt_fwd);
`else
        $display("%s: performance counters not built", tag);
`endif
    endtask

    vec_t tbl [28];

    initial begin
        // mk(v, rs1,u1, rs2,u2, rd,wr,ld, ms,br, exp stall,bubble,flush, exp sel1,sel2 after edge)
        tbl[0]  = mk(1, 1,1, 2,1,  5,1,0, 0,0, 0,0,0, 0,0); // add x5
        tbl[1]  = mk(1, 5,1, 6,1,  8,1,0, 0,0, 0,0,0, 1,0); // back-to-back on x5
        tbl[2]  = mk(1, 5,1, 8,1,  9,1,0, 0,0, 0,0,0, 2,1); // distance 2 and 1
        tbl[3]  = mk(1, 1,1, 0,0,  5,1,0, 0,0, 0,0,0, 0,0);
        tbl[4]  = mk(1, 1,1, 0,0,  5,1,0, 0,0, 0,0,0, 0,0);
        tbl[5]  = mk(1, 5,1, 0,0, 10,1,0, 0,0, 0,0,0, 1,0); // slot0 and slot1 both x5
        tbl[6]  = mk(1, 1,1, 0,0,  0,1,0, 0,0, 0,0,0, 0,0); // writes x0
        tbl[7]  = mk(1, 0,1,10,0, 11,1,0, 0,0, 0,0,0, 0,0); // x0 producer, rs2 unused
        tbl[8]  = mk(1, 1,1, 0,0,  7,1,1, 0,0, 0,0,0, 0,0); // lw x7
        tbl[9]  = mk(1, 7,1, 2,1, 12,1,0, 0,0, 1,1,0, 0,0); // load-use
        tbl[10] = mk(1, 7,1, 2,1, 12,1,0, 0,0, 0,0,0, 2,0); // released, tap 2
        tbl[11] = mk(1, 1,1, 0,0,  7,1,1, 0,0, 0,0,0, 0,0); // lw x7
        tbl[12] = mk(1, 3,1, 4,1, 13,1,0, 0,0, 0,0,0, 0,0); // independent
        tbl[13] = mk(1, 1,1, 0,0,  7,1,1, 0,0, 0,0,0, 0,0); // lw x7
        tbl[14] = mk(1, 7,1, 2,1, 12,1,0, 0,1, 0,1,1, 0,0); // branch beats load-use
        tbl[15] = mk(1, 7,1, 2,1, 12,1,0, 0,0, 0,0,0, 2,0);
        tbl[16] = mk(1, 1,1, 0,0,  7,1,1, 0,0, 0,0,0, 0,0); // lw x7
        tbl[17] = mk(1, 7,1, 2,1, 12,1,0, 1,1, 1,0,0, 0,0); // mem_stall beats branch
        tbl[18] = mk(1, 7,1, 2,1, 12,1,0, 0,0, 1,1,0, 0,0);
        tbl[19] = mk(1, 7,1, 2,1, 12,1,0, 0,0, 0,0,0, 2,0);
        tbl[20] = mk(1, 1,1, 0,0,  5,1,0, 0,0, 0,0,0, 0,0);
        tbl[21] = mk(1, 5,1, 6,1,  8,1,0, 0,0, 0,0,0, 1,0);
        tbl[22] = mk(1, 5,1, 0,0,  7,1,1, 0,0, 0,0,0, 2,0); // lw x7, selects nonzero
        tbl[23] = mk(1, 7,1, 2,1, 12,1,0, 1,0, 1,0,0, 2,0); // freeze x3, selects held
        tbl[24] = mk(1, 7,1, 2,1, 12,1,0, 1,0, 1,0,0, 2,0);
        tbl[25] = mk(1, 7,1, 2,1, 12,1,0, 1,0, 1,0,0, 2,0);
        tbl[26] = mk(1, 7,1, 2,1, 12,1,0, 0,0, 1,1,0, 0,0); // stall still one cycle
        tbl[27] = mk(1, 7,1, 2,1, 12,1,0, 0,0, 0,0,0, 2,0);
    end

    initial begin
        vec_t r;
        model_reset();

        // Reset state
        #12;
        chk("reset_sel1", int'(fwd_sel_rs1), 0);
        chk("reset_sel2", int'(fwd_sel_rs2), 0);
        chk("reset_stall", int'(stall_if_id), 0);
        chk("reset_bubble", int'(bubble_ex), 0);
        chk("reset_flush", int'(flush_if_id), 0);
        chk_perf("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 28; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Randomized run against the model
        for (int i = 0; i < 400; i++) begin
            bit st, bu, fl;
            int s1, s2;
            r = mk($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 4) != 0,
                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0, 0, 0, 0, 0, 0);
            step(r, st, bu, fl, s1, s2);
            $display("rand%0d: v=%0d rs1=%0d rs2=%0d rd=%0d ld=%0d ms=%0d br=%0d stall=%0d bubble=%0d flush=%0d sel=%0d/%0d",
                     i, r.v, r.rs1, r.rs2, r.rd, r.ld, r.ms, r.br, st, bu, fl, s1, s2);
        end
        chk_perf("pre_reset");

        // Asynchronous reset in the middle of a load-use stall
        run_vec("rst_a", mk(1, 1,1, 0,0,  5,1,0, 0,0, 0,0,0, 0,0));
        run_vec("rst_b", mk(1, 5,1, 0,0,  7,1,1, 0,0, 0,0,0, 1,0));
        id_valid = 1'b1; id_rs1 = REG_AW'(7); id_rs1_used = 1'b1; id_rs2_used = 1'b0;
        id_rd = REG_AW'(12); id_regwrite = 1'b1; id_memread = 1'b0;
        mem_stall = 1'b0; ex_branch_taken = 1'b0;
        #1;
        chk("rst_pre_stall", int'(stall_if_id), 1);
        chk("rst_pre_sel1", int'(fwd_sel_rs1), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_stall", int'(stall_if_id), 0);
        chk("rst_async_bubble", int'(bubble_ex), 0);
        chk("rst_async_sel1", int'(fwd_sel_rs1), 0);
        model_reset();
        chk_perf("rst_async");
        $display("async reset applied at t=%0t", $time);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("rst_c", mk(1, 7,1, 2,1, 12,1,0, 0,0, 0,0,0, 0,0)); // empty pipe: no stall
        run_vec("rst_d", mk(1, 1,1, 0,0,  5,1,0, 0,0, 0,0,0, 0,0));
        run_vec("rst_e", mk(1, 5,1, 0,0,  8,1,0, 0,0, 0,0,0, 1,0));
        chk_perf("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Parametrised hazard and forwarding controller for the in-order RISC-V core pipeline. It keeps its own tag pipeline of in-flight destination registers, so the datapath no longer routes stage-register fields back into it. Forwarding selects are resolved one stage early, in ID, and registered so they are stable for the whole EX cycle. The block also generates load-use stalls, freezes on memory stalls and squashes on taken branches. It sits beside the ID/EX pipeline register and drives the EX operand muxes plus the IF/ID and ID/EX hold, flush and bubble controls.

## Interface
- REG_AW, 5: register-address width.
- FWD_DEPTH, 2: number of downstream result taps that can forward. Tap k is the output of stage EX+k, so 1 = EX/MEM and 2 = MEM/WB.
- LOAD_FWD_SEL, 2: lowest tap at which load data exists; must be ≤ FWD_DEPTH.
- SELW, $clog2(FWD_DEPTH+1): forward-select width. Derived; do not override.
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  source registers.
- id_rs1_used, id_rs2_used  in  1  operand actually read.
- id_rd  in  REG_AW  destination register.
- id_regwrite  in  1  instruction writes rd.
- id_memread  in  1  instruction is a load.
- mem_stall  in  1  I$ or D$ busy; whole pipe freezes.
- ex_branch_taken  in  1  branch or jump resolved taken in EX.
- fwd_sel_rs1, fwd_sel_rs2  out  SELW  EX operand select. 0 = register file, k = tap k. Registered.
- stall_if_id  out  1  hold PC and IF/ID. Combinational.
- bubble_ex  out  1  load a NOP into ID/EX. Combinational.
- flush_if_id  out  1  kill the IF/ID contents. Combinational.

## Operation
- **Tag slots.** slot[0..FWD_DEPTH] mirror EX, MEM, … Each slot holds {valid, rd, regwrite, memread}.
- **Slot advance.** On an advance, slot[j+1] ← slot[j]. slot[0] ← the ID tag if id_valid && !stall && !flush, otherwise a bubble (valid=0).
- **Match condition.** A slot j matches operand rsX when all of these hold: valid, regwrite, rd≠0, rd==id_rsX, id_rsX_used.
- **Forward select.** The youngest matching slot j < FWD_DEPTH gives a next select of j+1. With no match, the select is 0.
- **WB slot.** A match in slot[FWD_DEPTH] gives select 0. The register file is write-through.
- **Load-use stall.** Raised when a matching slot j has memread=1 and j+1 < LOAD_FWD_SEL.
- **Load-use outputs.** stall_if_id=1 and bubble_ex=1. The forward selects register 0 (bubble). The tags still advance, so the stall clears once the load reaches a usable tap.
- **Memory stall.** When mem_stall=1: stall_if_id=1, bubble_ex=0, flush_if_id=0. Slots and forward-select registers hold their values. Load-use and flush evaluation are suppressed.
- **Taken branch.** When ex_branch_taken=1 and mem_stall=0: flush_if_id=1 and bubble_ex=1. slot[0] ← bubble and the forward selects ← 0. Any load-use stall is cancelled because the dependent instruction is squashed.
- **Priority.** mem_stall > ex_branch_taken > load-use > normal.

## Timing
- **Reset.** Asynchronous; all slots invalid, fwd_sel_rs1/rs2 = 0. The combinational outputs are 0 while there are no inputs.
- **Forward-select latency.** Computed in the cycle the consumer is in ID, registered at the edge it enters EX, valid for the full EX cycle.
- **Stall/flush/bubble latency.** Zero: same cycle as the causing input or slot state.
- **Load-use length.** With default parameters, a load immediately followed by a dependent instruction stalls exactly 1 cycle, then gives select 2. A general stall lasts LOAD_FWD_SEL−1−j cycles.
- **rst_n mid-operation.** Clears immediately. The first cycle after release behaves as an empty pipe.

## Configuration
- **HAZARD_PERF_EN defined.** Adds outputs perf_loaduse (32 b), perf_flush (32 b) and perf_fwd (32 b).
  - perf_loaduse counts load-use stall cycles.
  - perf_flush counts taken-branch flushes.
  - perf_fwd counts EX cycles with any nonzero select.
  - The counters are frozen during mem_stall, saturate at all-ones and reset to 0.
- **HAZARD_PERF_EN undefined.** The ports and counters are absent; behaviour is otherwise identical.

## Structure
- **hazard_pkg.** Holds the tag struct typedef {valid, rd, regwrite, memread}, the constant FWD_RF = 0 and the bubble tag constant.
- **hazard_tag_pipe.** One sub-module holding the slot shift register with hold/insert/bubble controls. Match, priority and stall logic live in the top module.

## Test plan
- **ALU back-to-back.** add x5 then sub using x5 as rs1 → in sub's EX cycle, fwd_sel_rs1=1 and fwd_sel_rs2=0.
- **Forwarding distance and filters.**
  - Producer x5 two instructions ahead → select 2.
  - Both slot0 and slot1 write x5 → select 1 (youngest wins).
  - Producer rd=x0, or consumer rs1_used=0 → select 0.
- **Load-use.** lw x7 followed by add using x7 → exactly 1 cycle with stall_if_id=1 and bubble_ex=1, then add enters EX with select 2. lw x7 followed by an independent instruction → no stall.
- **Memory freeze.** mem_stall held 3 cycles during a load-use sequence → slots and selects unchanged, bubble_ex=0. After release, the stall completes with the same cycle count as without mem_stall.
- **Branch vs load-use.** ex_branch_taken coincides with a load-use condition → flush_if_id=1, bubble_ex=1, no stall, selects 0 next cycle. Same cycle with mem_stall=1 → freeze only.
- **Async reset.** rst_n asserted mid-stream, asynchronously (off-edge) → outputs and selects 0 immediately. After release, the first dependent pair behaves as from an empty pipe. With HAZARD_PERF_EN, the counters match the event counts above.
